// File: rtl/tt_vpu_ovi_pkg.sv
// Shared defaults and types for the OVI issue/completion controller.
package tt_vpu_ovi_pkg;

  // Default scoreboard-ID width used on the OVI completion interface.
  localparam int SBID_W_DEFAULT = 5;

  // Issue-FIFO depth, which is also the initial credit count held by the core.
  localparam int OVI_CREDITS_DEFAULT = 4;

  typedef logic [SBID_W_DEFAULT-1:0] sb_id_t;

endpackage : tt_vpu_ovi_pkg

// File: rtl/tt_vpu_sbid_queue.sv
// In-order synchronous queue of scoreboard IDs with push/pop/full/empty/count.
// A push while full is accepted only if a pop frees a slot in the same cycle.
// The head entry is presented combinationally from the storage array.
module tt_vpu_sbid_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 5
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : tt_vpu_sbid_queue

// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// OVI issue/completion controller: returns issue credits as FIFO entries
// leave, tags pipeline commits with in-order sb_ids, throttles pipeline
// reads when the in-flight tracker is full, and records protocol errors.
module tt_vpu_ovi_issue_ctrl
  import tt_vpu_ovi_pkg::*;
#(
  parameter int CREDITS  = OVI_CREDITS_DEFAULT,
  parameter int INFLIGHT = 8,
  parameter int SBID_W   = SBID_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          issue_valid,
  output logic                          issue_credit,
  input  logic                          fifo_pop,
  input  logic [SBID_W-1:0]             fifo_pop_sb_id,
  input  logic                          fifo_drop,
  output logic                          pipe_ready,
  input  logic                          commit_valid,
  output logic                          completed_valid,
  output logic [SBID_W-1:0]             completed_sb_id,
  output logic [$clog2(INFLIGHT+1)-1:0] inflight_cnt,
  output logic                          err_overflow,
  output logic                          err_underflow
);

  localparam int OW = $clog2(CREDITS+1);
  localparam int CW = $clog2(INFLIGHT+1);

  logic [OW-1:0]     r_fifo_occ;
  logic [OW-1:0]     r_pend_credits;
  logic              r_err_overflow;
  logic              r_err_underflow;
  logic              r_completed_valid;
  logic [SBID_W-1:0] r_completed_sb_id;

  logic [OW:0]       w_occ_up;
  logic [OW:0]       w_release;
  logic [OW:0]       w_pend_sum;
  logic [OW-1:0]     w_occ_next;
  logic [OW-1:0]     w_pend_next;
  logic              w_credit;
  logic [SBID_W-1:0] w_q_head;
  logic              w_q_full;
  logic              w_q_empty;
  logic [CW-1:0]     w_q_count;

  tt_vpu_sbid_queue #(
    .DEPTH (INFLIGHT),
    .W     (SBID_W)
  ) u_sbid_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (fifo_pop),
    .i_push_data (fifo_pop_sb_id),
    .i_pop       (commit_valid),
    .o_head      (w_q_head),
    .o_full      (w_q_full),
    .o_empty     (w_q_empty),
    .o_count     (w_q_count)
  );

  // One credit per cycle leaves the pending pool as soon as it is non-zero.
  assign w_credit = (r_pend_credits != '0);

  // Next FIFO occupancy and pending-credit count, both saturating.
  always_comb begin
    w_occ_up    = {1'b0, r_fifo_occ} + (OW+1)'(issue_valid);
    w_release   = (OW+1)'(fifo_pop) + (OW+1)'(fifo_drop);
    w_occ_next  = '0;
    w_pend_sum  = {1'b0, r_pend_credits} + w_release - (OW+1)'(w_credit);
    w_pend_next = '0;
    // An issue into a full FIFO is lost; occupancy cannot exceed CREDITS.
    if (w_occ_up > (OW+1)'(CREDITS)) begin
      w_occ_up = (OW+1)'(CREDITS);
    end
    // Pop/drop from an empty FIFO is a caller error; hold at zero.
    if (w_occ_up >= w_release) begin
      w_occ_next = OW'(w_occ_up - w_release);
    end
    if (w_pend_sum > (OW+1)'(CREDITS)) begin
      w_pend_next = OW'(CREDITS);
    end else begin
      w_pend_next = OW'(w_pend_sum);
    end
  end

  // Counters, sticky error flags and the registered completion strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fifo_occ        <= '0;
      r_pend_credits    <= '0;
      r_err_overflow    <= 1'b0;
      r_err_underflow   <= 1'b0;
      r_completed_valid <= 1'b0;
      r_completed_sb_id <= '0;
    end else begin
      r_fifo_occ     <= w_occ_next;
      r_pend_credits <= w_pend_next;
      if (issue_valid && (r_fifo_occ == OW'(CREDITS))) begin
        r_err_overflow <= 1'b1;
      end
      if (commit_valid && w_q_empty) begin
        r_err_underflow <= 1'b1;
      end
      r_completed_valid <= commit_valid && !w_q_empty;
      if (commit_valid && !w_q_empty) begin
        r_completed_sb_id <= w_q_head;
      end
    end
  end

  assign issue_credit    = w_credit;
  assign pipe_ready      = (w_q_count < CW'(INFLIGHT));
  assign completed_valid = r_completed_valid;
  assign completed_sb_id = r_completed_sb_id;
  assign inflight_cnt    = w_q_count;
  assign err_overflow    = r_err_overflow;
  assign err_underflow   = r_err_underflow;

  // The pipeline must honour pipe_ready; a pop into a full tracker is dropped.
  a_no_pop_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_pop && w_q_full && !commit_valid));

endmodule : tt_vpu_ovi_issue_ctrl

// File: tb/tb_tt_vpu_ovi_issue_ctrl.sv
// Directed testbench for tt_vpu_ovi_issue_ctrl with hand-computed expectations.
module tb_tt_vpu_ovi_issue_ctrl;

  logic       clk;
  logic       reset_n;
  logic       issue_valid;
  logic       issue_credit;
  logic       fifo_pop;
  logic [4:0] fifo_pop_sb_id;
  logic       fifo_drop;
  logic       pipe_ready;
  logic       commit_valid;
  logic       completed_valid;
  logic [4:0] completed_sb_id;
  logic [3:0] inflight_cnt;
  logic       err_overflow;
  logic       err_underflow;

  int n_vec = 0;
  int n_err = 0;

  tt_vpu_ovi_issue_ctrl #(.CREDITS(4), .INFLIGHT(8), .SBID_W(5)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .issue_valid     (issue_valid),
    .issue_credit    (issue_credit),
    .fifo_pop        (fifo_pop),
    .fifo_pop_sb_id  (fifo_pop_sb_id),
    .fifo_drop       (fifo_drop),
    .pipe_ready      (pipe_ready),
    .commit_valid    (commit_valid),
    .completed_valid (completed_valid),
    .completed_sb_id (completed_sb_id),
    .inflight_cnt    (inflight_cnt),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_vec++; if (issue_credit !== 1'b0) begin n_err++; $display("FAIL reset_credit: got %0b want 0", issue_credit); end
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL reset_cv: got %0b want 0", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd0) begin n_err++; $display("FAIL reset_sbid: got %0d want 0", completed_sb_id); end
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", pipe_ready); end
    n_vec++; if (inflight_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", inflight_cnt); end
    n_vec++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", err_overflow); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_unf: got %0b want 0", err_underflow); end
    $display("test_reset done: credit=%0b cv=%0b ready=%0b cnt=%0d", issue_credit, completed_valid, pipe_ready, inflight_cnt);
  endtask

  // Issue sb_id 3, pop at N, commit at N+5.
  task automatic test_single();
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    n_vec++; if (issue_credit !== 1'b0) begin n_err++; $display("FAIL single_credit_issue: got %0b want 0", issue_credit); end
    fifo_pop = 1'b1; fifo_pop_sb_id = 5'd3;                 // cycle N
    tick();                                                 // now N+1
    fifo_pop = 1'b0;
    n_vec++; if (issue_credit !== 1'b1) begin n_err++; $display("FAIL single_credit_n1: got %0b want 1", issue_credit); end
    n_vec++; if (inflight_cnt !== 4'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", inflight_cnt); end
    tick();                                                 // N+2
    n_vec++; if (issue_credit !== 1'b0) begin n_err++; $display("FAIL single_credit_n2: got %0b want 0", issue_credit); end
    tick(); tick(); tick();                                 // N+5
    commit_valid = 1'b1;
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL single_cv_early: got %0b want 0", completed_valid); end
    tick();                                                 // N+6
    commit_valid = 1'b0;
    n_vec++; if (completed_valid !== 1'b1) begin n_err++; $display("FAIL single_cv: got %0b want 1", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd3) begin n_err++; $display("FAIL single_sbid: got %0d want 3", completed_sb_id); end
    tick();
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL single_cv_drop: got %0b want 0", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd3) begin n_err++; $display("FAIL single_sbid_hold: got %0d want 3", completed_sb_id); end
    $display("test_single done: completed_sb_id=%0d cnt=%0d", completed_sb_id, inflight_cnt);
  endtask

  // Simultaneous pop (sb_id 7) and drop: two credit pulses on consecutive cycles.
  task automatic test_pop_drop();
    issue_valid = 1'b1;
    tick(); tick();
    issue_valid = 1'b0;
    fifo_pop = 1'b1; fifo_pop_sb_id = 5'd7; fifo_drop = 1'b1;
    tick();
    fifo_pop = 1'b0; fifo_drop = 1'b0;
    n_vec++; if (issue_credit !== 1'b1) begin n_err++; $display("FAIL popdrop_credit_n1: got %0b want 1", issue_credit); end
    n_vec++; if (inflight_cnt !== 4'd1) begin n_err++; $display("FAIL popdrop_cnt: got %0d want 1", inflight_cnt); end
    tick();
    n_vec++; if (issue_credit !== 1'b1) begin n_err++; $display("FAIL popdrop_credit_n2: got %0b want 1", issue_credit); end
    tick();
    n_vec++; if (issue_credit !== 1'b0) begin n_err++; $display("FAIL popdrop_credit_n3: got %0b want 0", issue_credit); end
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    n_vec++; if (completed_sb_id !== 5'd7) begin n_err++; $display("FAIL popdrop_sbid: got %0d want 7", completed_sb_id); end
    n_vec++; if (inflight_cnt !== 4'd0) begin n_err++; $display("FAIL popdrop_cnt_end: got %0d want 0", inflight_cnt); end
    $display("test_pop_drop done: completed_sb_id=%0d cnt=%0d", completed_sb_id, inflight_cnt);
  endtask

  // Fill the tracker, commit from full, commit+pop at full, then drain in order.
  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      fifo_pop = 1'b1; fifo_pop_sb_id = 5'(i);
      tick();
      n_vec++; if (inflight_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL full_cnt[%0d]: got %0d want %0d", i, inflight_cnt, i + 1); end
      n_vec++; if (pipe_ready !== (i < 7)) begin n_err++; $display("FAIL full_ready[%0d]: got %0b want %0b", i, pipe_ready, (i < 7)); end
    end
    fifo_pop = 1'b0;
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    n_vec++; if (completed_valid !== 1'b1) begin n_err++; $display("FAIL full_cv: got %0b want 1", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd0) begin n_err++; $display("FAIL full_sbid0: got %0d want 0", completed_sb_id); end
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after: got %0b want 1", pipe_ready); end
    n_vec++; if (inflight_cnt !== 4'd7) begin n_err++; $display("FAIL full_cnt7: got %0d want 7", inflight_cnt); end
    fifo_pop = 1'b1; fifo_pop_sb_id = 5'd8;
    tick();
    n_vec++; if (pipe_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_refill: got %0b want 0", pipe_ready); end
    fifo_pop_sb_id = 5'd9; commit_valid = 1'b1;
    tick();
    fifo_pop = 1'b0;
    n_vec++; if (inflight_cnt !== 4'd8) begin n_err++; $display("FAIL full_cnt_swap: got %0d want 8", inflight_cnt); end
    n_vec++; if (completed_sb_id !== 5'd1) begin n_err++; $display("FAIL full_sbid1: got %0d want 1", completed_sb_id); end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++; if (completed_valid !== 1'b1 || completed_sb_id !== 5'(i + 2)) begin
        n_err++; $display("FAIL full_drain[%0d]: got cv=%0b sbid=%0d want cv=1 sbid=%0d", i, completed_valid, completed_sb_id, i + 2);
      end
    end
    commit_valid = 1'b0;
    tick();
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL full_cv_end: got %0b want 0", completed_valid); end
    n_vec++; if (inflight_cnt !== 4'd0) begin n_err++; $display("FAIL full_cnt_end: got %0d want 0", inflight_cnt); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL full_unf: got %0b want 0", err_underflow); end
    for (int i = 0; i < 4; i++) tick();
    $display("test_full done: cnt=%0d ready=%0b last_sbid=%0d", inflight_cnt, pipe_ready, completed_sb_id);
  endtask

  // Five issues with no pops into a 4-entry FIFO.
  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1;
      tick();
      n_vec++; if (err_overflow !== (i == 4)) begin n_err++; $display("FAIL ovf_issue[%0d]: got %0b want %0b", i, err_overflow, (i == 4)); end
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++; if (err_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", err_overflow); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL ovf_unf: got %0b want 0", err_underflow); end
    $display("test_overflow done: err_overflow=%0b", err_overflow);
  endtask

  // Commit with an empty tracker, commit+push while empty, then reset clears flags.
  task automatic test_underflow();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    n_vec++; if (err_underflow !== 1'b1) begin n_err++; $display("FAIL unf_flag: got %0b want 1", err_underflow); end
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL unf_cv: got %0b want 0", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd9) begin n_err++; $display("FAIL unf_sbid_hold: got %0d want 9", completed_sb_id); end
    commit_valid = 1'b1; fifo_pop = 1'b1; fifo_pop_sb_id = 5'd5;
    tick();
    fifo_pop = 1'b0;
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL unf_push_cv: got %0b want 0", completed_valid); end
    n_vec++; if (inflight_cnt !== 4'd1) begin n_err++; $display("FAIL unf_push_cnt: got %0d want 1", inflight_cnt); end
    tick();
    commit_valid = 1'b0;
    n_vec++; if (completed_valid !== 1'b1 || completed_sb_id !== 5'd5) begin
      n_err++; $display("FAIL unf_commit: got cv=%0b sbid=%0d want cv=1 sbid=5", completed_valid, completed_sb_id);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++; if (err_overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0b want 0", err_overflow); end
    n_vec++; if (err_underflow !== 1'b0) begin n_err++; $display("FAIL rst_unf: got %0b want 0", err_underflow); end
    n_vec++; if (completed_valid !== 1'b0) begin n_err++; $display("FAIL rst_cv: got %0b want 0", completed_valid); end
    n_vec++; if (completed_sb_id !== 5'd0) begin n_err++; $display("FAIL rst_sbid: got %0d want 0", completed_sb_id); end
    n_vec++; if (pipe_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b want 1", pipe_ready); end
    $display("test_underflow done: ovf=%0b unf=%0b", err_overflow, err_underflow);
  endtask

  initial begin
    reset_n        = 1'b0;
    issue_valid    = 1'b0;
    fifo_pop       = 1'b0;
    fifo_pop_sb_id = 5'd0;
    fifo_drop      = 1'b0;
    commit_valid   = 1'b0;
    test_reset();
    test_single();
    test_pop_drop();
    test_full();
    test_overflow();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tt_vpu_ovi_issue_ctrl
